gba_bw_intro_fetch_ctrl: RTL and testbench

Read sequencer for the four 64-byte black-and-white intro-image block RAMs (banks 0..3, 256 bytes total, bank 0 first). On a start pulse it walks every bank address in order, issues one-cycle-latency reads, selects the returning byte and delivers the image as a valid/ready byte stream to the downstream display/serializer. It owns all bank read enables and the shared read address; no other block reads the image banks while it is busy.

---
 rtl/gba_intro_pkg.sv | 16 +
 rtl/gba_bw_intro_fetch_ctrl_if.sv | 26 ++
 rtl/gba_intro_skid_fifo.sv | 58 +++++
 rtl/gba_bw_intro_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_gba_bw_intro_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gba_intro_pkg.sv
// rtl/gba_intro_pkg.sv - shared types and constants for the intro-image fetch path
package gba_intro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_BANKS  = 4;
    localparam int BANK_DEPTH = 64;
    localparam int IMG_BYTES  = NUM_BANKS * BANK_DEPTH;
    localparam int BUF_DEPTH  = 2;

endpackage

// File: rtl/gba_bw_intro_fetch_ctrl_if.sv
// rtl/gba_bw_intro_fetch_ctrl_if.sv - control, bank-read and pixel-stream signals of the fetch controller
interface gba_bw_intro_fetch_ctrl_if #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 6
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [NUM_BANKS-1:0]   ram_rd_en;
    logic [ADDR_W-1:0]      ram_rd_addr;
    logic [8*NUM_BANKS-1:0] ram_data_in;
    logic [NUM_BANKS-1:0]   ram_valid_in;
    logic [7:0]             pix_data;
    logic                   pix_valid;
    logic                   pix_ready;

    modport master (
        input  start, ram_data_in, ram_valid_in, pix_ready,
        output busy, done, ram_rd_en, ram_rd_addr, pix_data, pix_valid
    );

    modport slave (
        output start, ram_data_in, ram_valid_in, pix_ready,
        input  busy, done, ram_rd_en, ram_rd_addr, pix_data, pix_valid
    );
endinterface

// File: rtl/gba_intro_skid_fifo.sv
// rtl/gba_intro_skid_fifo.sv - two-entry byte FIFO holding returned bank data ahead of the pixel stream
module gba_intro_skid_fifo
    import gba_intro_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic [1:0] occupancy
);
    logic [7:0] mem_q [BUF_DEPTH];
    logic [7:0] mem_d [BUF_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        // A full buffer still takes a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != 2'(BUF_DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = count_q;
endmodule

// File: rtl/gba_bw_intro_fetch_ctrl.sv
// rtl/gba_bw_intro_fetch_ctrl.sv - walks all intro-image banks and streams the bytes downstream
module gba_bw_intro_fetch_ctrl #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic clk,
    input  logic rst,
    gba_bw_intro_fetch_ctrl_if.master bus
);
    import gba_intro_pkg::*;

    localparam int IMG_N  = NUM_BANKS * BANK_DEPTH;
    localparam int IDX_W  = $clog2(IMG_N);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W  = IDX_W + 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic               in_flight_q, in_flight_d;
    logic [BANK_W-1:0]  rd_bank_q, rd_bank_d;

    logic               issue;
    logic               credit_ok;
    logic               last_pop;
    logic               push;
    logic               pop;
    logic [7:0]         push_data;
    logic [1:0]         occ;
    logic [BANK_W-1:0]  bank;

    assign bank = idx_q[IDX_W-1 -: BANK_W];
    assign pop  = bus.pix_valid && bus.pix_ready;

    // Only the bank read last cycle may deliver; stray valids elsewhere are dropped.
    assign push      = in_flight_q && bus.ram_valid_in[rd_bank_q];
    assign push_data = bus.ram_data_in[{rd_bank_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pop_cnt_d = pop_cnt_q;
        issue     = 1'b0;
        // Buffered plus in-flight bytes, less the one leaving now, must leave a free slot.
        credit_ok = ({1'b0, occ} + {2'b00, in_flight_q}) < (3'(BUF_DEPTH) + {2'b00, pop});
        last_pop  = pop && (pop_cnt_q == CNT_W'(IMG_N - 1));

        if (pop && (pop_cnt_q != CNT_W'(IMG_N))) begin
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = FETCH;
                    idx_d     = '0;
                    pop_cnt_d = '0;
                end
            end
            FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(IMG_N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_flight_d = issue;
        rd_bank_d   = issue ? bank : rd_bank_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pop_cnt_q   <= '0;
            in_flight_q <= 1'b0;
            rd_bank_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pop_cnt_q   <= pop_cnt_d;
            in_flight_q <= in_flight_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    gba_intro_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (bus.pix_data),
        .occupancy (occ)
    );

    assign bus.pix_valid   = (occ != 2'd0);
    assign bus.ram_rd_en   = issue ? (NUM_BANKS'(1) << bank) : '0;
    assign bus.ram_rd_addr = issue ? idx_q[ADDR_W-1:0] : '0;
    assign bus.busy        = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_gba_bw_intro_fetch_ctrl.sv
// tb/tb_gba_bw_intro_fetch_ctrl.sv - self-checking bench for the intro-image fetch controller
`timescale 1ns/1ps
module tb_gba_bw_intro_fetch_ctrl;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic [3:0] rd_en;
        logic [5:0] addr;
        logic       pv;
        logic [7:0] data;
    } vec_t;

    localparam int NV = 9;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] inj_valid;
    logic [7:0] mem [256];
    logic [7:0] got [$];
    vec_t tbl [NV];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int out_cnt = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    gba_bw_intro_fetch_ctrl_if #(.NUM_BANKS(4), .ADDR_W(6)) bus ();

    gba_bw_intro_fetch_ctrl #(.NUM_BANKS(4), .BANK_DEPTH(64), .ADDR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // One-cycle-latency bank RAM model.
    always @(posedge clk) begin
        bus.ram_valid_in <= bus.ram_rd_en | inj_valid;
        for (int b = 0; b < 4; b++) begin
            if (bus.ram_rd_en[b]) begin
                bus.ram_data_in[8*b +: 8] <= mem[b*64 + int'(bus.ram_rd_addr)];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(bus.pix_valid), 32'd1);
                check("stall_hold_data", 32'(bus.pix_data), 32'(prev_data));
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_data  = bus.pix_data;
            if (bus.pix_valid && bus.pix_ready) got.push_back(bus.pix_data);
            if (bus.done) done_cnt++;
            out_cnt += ((bus.ram_rd_en != 4'd0) ? 1 : 0) - ((bus.pix_valid && bus.pix_ready) ? 1 : 0);
            if (bus.ram_rd_en != 4'd0) begin
                rd_cnt++;
                check("rd_en_onehot", 32'($onehot(bus.ram_rd_en)), 32'd1);
                check("outstanding_le2", 32'(out_cnt <= 2), 32'd1);
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int pat, input int i);
        case (pat)
            1:       return 8'hFF;
            2:       return 8'(i) ^ 8'h5A;
            default: return 8'(i);
        endcase
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return (k % 2) == 0;
            2:       return !(k >= 1 && k <= 20);
            5:       return (k < NV) ? tbl[k].ready : 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic set_mem(input int pat);
        for (int i = 0; i < 256; i++) mem[i] = exp_byte(pat, i);
    endtask

    // mode 0: ready high, 1: ready toggles, 2: 20-cycle stall, 3: spurious start/valid, 5: table
    task automatic run_pass(input int mode, output int done_at);
        logic spur;
        spur    = 1'b0;
        done_at = -1;
        @(posedge clk); #1;
        got.delete();
        done_cnt  = 0;
        rd_cnt    = 0;
        bus.start = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
                inj_valid = 4'b0000;
            end
            bus.pix_ready = ready_for(mode, k);
            if (mode == 2 && k == 21) check("stall_two_reads", 32'(rd_cnt), 32'd2);
            if (mode == 3 && !spur && got.size() == 100) begin
                bus.start = 1'b1;
                inj_valid = 4'b1000;
                spur      = 1'b1;
            end
            @(negedge clk);
            if (mode == 5 && k < NV) begin
                check($sformatf("tbl%0d_busy", k), 32'(bus.busy), 32'(tbl[k].busy));
                check($sformatf("tbl%0d_rd_en", k), 32'(bus.ram_rd_en), 32'(tbl[k].rd_en));
                check($sformatf("tbl%0d_addr", k), 32'(bus.ram_rd_addr), 32'(tbl[k].addr));
                check($sformatf("tbl%0d_pv", k), 32'(bus.pix_valid), 32'(tbl[k].pv));
                if (tbl[k].pv) check($sformatf("tbl%0d_data", k), 32'(bus.pix_data), 32'(tbl[k].data));
            end
            if (mode == 0) begin
                case (k)
                    2: check("first_pv_low_c2", 32'(bus.pix_valid), 32'd0);
                    3: begin
                        check("first_pv_high_c3", 32'(bus.pix_valid), 32'd1);
                        check("first_byte_c3", 32'(bus.pix_data), 32'(mem[0]));
                    end
                    64:  check("bank0_last", 32'({bus.ram_rd_en, bus.ram_rd_addr}), {22'd0, 4'b0001, 6'd63});
                    65:  check("bank1_first", 32'({bus.ram_rd_en, bus.ram_rd_addr}), {22'd0, 4'b0010, 6'd0});
                    129: check("bank2_first", 32'({bus.ram_rd_en, bus.ram_rd_addr}), {22'd0, 4'b0100, 6'd0});
                    193: check("bank3_first", 32'({bus.ram_rd_en, bus.ram_rd_addr}), {22'd0, 4'b1000, 6'd0});
                    default: ;
                endcase
            end
            if (mode == 2 && k == 21) check("stall_resume_rd_en", 32'(bus.ram_rd_en), 32'd1);
            if (bus.done) begin
                done_at = k;
                check("busy_low_at_done", 32'(bus.busy), 32'd0);
                break;
            end
        end
        check("done_seen", 32'(done_at >= 0), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            bus.start     = 1'b0;
            inj_valid     = 4'b0000;
            bus.pix_ready = 1'b1;
        end
    endtask

    task automatic verify_pass(input string tag, input int pat, input int exp_done, input int done_at);
        int bad;
        bad = 0;
        if (exp_done >= 0) check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        check({tag, "_byte_count"}, 32'(got.size()), 32'd256);
        foreach (got[i]) if (got[i] !== exp_byte(pat, i)) bad++;
        check({tag, "_byte_errors"}, 32'(bad), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int d;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b0;
        inj_valid     = 4'b0000;
        set_mem(0);

        tbl[0] = '{ready: 1'b1, busy: 1'b0, rd_en: 4'b0000, addr: 6'd0, pv: 1'b0, data: 8'h00};
        tbl[1] = '{ready: 1'b1, busy: 1'b1, rd_en: 4'b0001, addr: 6'd0, pv: 1'b0, data: 8'h00};
        tbl[2] = '{ready: 1'b1, busy: 1'b1, rd_en: 4'b0001, addr: 6'd1, pv: 1'b0, data: 8'h00};
        tbl[3] = '{ready: 1'b0, busy: 1'b1, rd_en: 4'b0000, addr: 6'd0, pv: 1'b1, data: 8'h00};
        tbl[4] = '{ready: 1'b0, busy: 1'b1, rd_en: 4'b0000, addr: 6'd0, pv: 1'b1, data: 8'h00};
        tbl[5] = '{ready: 1'b0, busy: 1'b1, rd_en: 4'b0000, addr: 6'd0, pv: 1'b1, data: 8'h00};
        tbl[6] = '{ready: 1'b1, busy: 1'b1, rd_en: 4'b0001, addr: 6'd2, pv: 1'b1, data: 8'h00};
        tbl[7] = '{ready: 1'b1, busy: 1'b1, rd_en: 4'b0001, addr: 6'd3, pv: 1'b1, data: 8'h01};
        tbl[8] = '{ready: 1'b1, busy: 1'b1, rd_en: 4'b0001, addr: 6'd4, pv: 1'b1, data: 8'h02};

        #22;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_en", 32'(bus.ram_rd_en), 32'd0);
        check("rst_rd_addr", 32'(bus.ram_rd_addr), 32'd0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_pix_data", 32'(bus.pix_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (2) @(posedge clk);

        run_pass(5, d);
        verify_pass("table", 0, 262, d);

        run_pass(0, d);
        verify_pass("clean", 0, 259, d);

        set_mem(1);
        run_pass(1, d);
        verify_pass("toggle_ff", 1, -1, d);

        set_mem(2);
        run_pass(2, d);
        verify_pass("stall20", 2, 277, d);

        set_mem(0);
        run_pass(3, d);
        verify_pass("spurious", 0, 259, d);

        // Reset in the middle of a pass, then a stale valid right after release.
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.pix_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (got.size() >= 50) break;
        end
        got.delete();
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_rd_en", 32'(bus.ram_rd_en), 32'd0);
        check("midrst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("midrst_pix_data", 32'(bus.pix_data), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst       = 1'b0;
        inj_valid = 4'b0001;
        @(posedge clk); #1;
        inj_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("stale_valid_ignored", 32'(bus.pix_valid), 32'd0);
        run_pass(0, d);
        verify_pass("after_rst", 0, 259, d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
